fp32_norm_shift_seq: RTL

- Multi-cycle left-shift normalizer for the FP32 datapath.
- Accepts a raw mantissa/exponent pair and shifts the mantissa left one bit per cycle until its MSB is 1.
- An up-counter tracks the shift amount. This is the producer side of the shift-count path: it generates the counts that the loadable down-counters consume.
- Sits after the add/sub mantissa stage and before rounding/packing. Exponent is decremented in lockstep; it stops at the subnormal boundary.

---
 rtl/fp32_norm_shift_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fp32_norm_shift_seq.sv
// Multi-cycle left-shift normalizer for the FP32 datapath.
// Shifts the mantissa left one bit per cycle until its MSB is set. The
// exponent is decremented in lockstep and is floored at the subnormal
// boundary. The shift count is reported for downstream consumers.
module fp32_norm_shift_seq #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mant_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero,
  output logic             denorm
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] mant_w;
  logic [EXP_W-1:0] exp_w;
  logic [CNT_W-1:0] cnt;

  logic             stop;
  logic             stop_zero;
  logic             stop_denorm;
  logic [EXP_W-1:0] stop_exp;

  // Stop decode in priority order: zero, subnormal input, normalized,
  // exponent floor, counter safety limit.
  always_comb begin
    stop        = 1'b0;
    stop_zero   = 1'b0;
    stop_denorm = 1'b0;
    stop_exp    = exp_w;
    if (mant_w == '0) begin
      stop      = 1'b1;
      stop_zero = 1'b1;
      stop_exp  = '0;
    end else if (exp_w == '0) begin
      stop        = 1'b1;
      stop_denorm = 1'b1;
      stop_exp    = '0;
    end else if (mant_w[WIDTH-1]) begin
      stop = 1'b1;
    end else if (exp_w == EXP_ONE) begin
      stop        = 1'b1;
      stop_denorm = 1'b1;
      stop_exp    = '0;
    end else if (cnt == CNT_MAX) begin
      stop = 1'b1;
    end
  end

  // Sequencer: accept in IDLE, shift until a stop condition, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mant_w    <= '0;
      exp_w     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      shift_cnt <= '0;
      zero      <= 1'b0;
      denorm    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mant_w <= mant_in;
            exp_w  <= exp_in;
            cnt    <= '0;
            zero   <= 1'b0;
            denorm <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (stop) begin
            mant_out  <= mant_w;
            exp_out   <= stop_exp;
            shift_cnt <= cnt;
            zero      <= stop_zero;
            denorm    <= stop_denorm;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            mant_w <= {mant_w[WIDTH-2:0], 1'b0};
            exp_w  <= exp_w - EXP_ONE;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
